// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic id_flush;
    logic ex_flush;
  } hz_ctrl_t;

  // Saturating increment for the 32-bit performance counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and stall/flush/redirect controls.
interface pipeline_hazard_ctrl_if
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      ex_rd;
  logic            ex_mem_read;
  logic            ex_branch_taken;
  logic [XLEN-1:0] ex_branch_target;
  logic            mem_busy;

  logic            if_stall;
  logic            id_stall;
  logic            ex_stall;
  logic            id_flush;
  logic            ex_flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_err;
  logic            mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, mem_busy,
    input  if_stall, id_stall, ex_stall, id_flush, ex_flush,
           redirect_valid, redirect_pc, misalign_err, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, ex_branch_target, mem_busy,
    output if_stall, id_stall, ex_stall, id_flush, ex_flush,
           redirect_valid, redirect_pc, misalign_err, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID operands and the EX load.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_mem_read,
  output logic       o_load_use
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit  = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);
  assign o_load_use = i_ex_mem_read && (i_ex_rd != REG_ZERO) && (w_rs1_hit || w_rs2_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage pipeline (Mealy outputs).
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEF,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flushes,
  output logic [31:0]           perf_loaduse
`endif
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned FCNT_W = 3;

  hz_state_t          r_state;
  logic [FCNT_W-1:0]  r_fcnt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic               r_mem_timeout;

  hz_state_t          w_state_nxt;
  logic [FCNT_W-1:0]  w_fcnt_nxt;
  logic [WCNT_W-1:0]  w_wcnt_nxt;
  logic               w_timeout_set;
  logic               w_run_eval;
  logic               w_load_use;
  hz_ctrl_t           w_ctrl;
  logic               w_redirect;
  logic               w_misalign;

  hazard_detect u_hazard_detect (
    .i_id_rs1      (bus.id_rs1),
    .i_id_rs2      (bus.id_rs2),
    .i_id_use_rs1  (bus.id_use_rs1),
    .i_id_use_rs2  (bus.id_use_rs2),
    .i_ex_rd       (bus.ex_rd),
    .i_ex_mem_read (bus.ex_mem_read),
    .o_load_use    (w_load_use)
  );

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_fcnt        <= '0;
      r_wcnt        <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fcnt        <= w_fcnt_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_mem_timeout <= r_mem_timeout | w_timeout_set;
    end
  end

  // Next-state and Mealy output decode; priority mem_busy > branch > load-use.
  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_set = 1'b0;
    w_run_eval    = 1'b0;
    w_ctrl        = '0;
    w_redirect    = 1'b0;
    w_misalign    = 1'b0;

    case (r_state)
      RUN: w_run_eval = 1'b1;

      LOAD_STALL: begin
        if (bus.mem_busy) begin
          w_ctrl.if_stall = 1'b1;
          w_ctrl.id_stall = 1'b1;
          w_ctrl.ex_stall = 1'b1;
          w_state_nxt     = MEM_WAIT;
          w_wcnt_nxt      = WCNT_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end

      FLUSH: begin
        if (bus.mem_busy) begin
          // Remaining flush count is dropped; IF/ID already holds a bubble.
          w_ctrl.if_stall = 1'b1;
          w_ctrl.id_stall = 1'b1;
          w_ctrl.ex_stall = 1'b1;
          w_state_nxt     = MEM_WAIT;
          w_wcnt_nxt      = WCNT_W'(1);
          w_fcnt_nxt      = '0;
        end else if (bus.ex_branch_taken) begin
          w_redirect      = 1'b1;
          w_misalign      = |bus.ex_branch_target[1:0];
          w_ctrl.id_flush = 1'b1;
          w_ctrl.ex_flush = 1'b1;
          w_fcnt_nxt      = FCNT_W'(FLUSH_DEPTH - 1);
          w_state_nxt     = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
        end else begin
          w_ctrl.id_flush = 1'b1;
          w_fcnt_nxt      = r_fcnt - FCNT_W'(1);
          if (r_fcnt <= FCNT_W'(1)) begin
            w_state_nxt = RUN;
            w_fcnt_nxt  = '0;
          end
        end
      end

      MEM_WAIT: begin
        if (bus.mem_busy) begin
          w_ctrl.if_stall = 1'b1;
          w_ctrl.id_stall = 1'b1;
          w_ctrl.ex_stall = 1'b1;
          if (r_wcnt >= WCNT_W'(MEM_TIMEOUT)) begin
            w_timeout_set = 1'b1;
            w_state_nxt   = RUN;
            w_wcnt_nxt    = '0;
          end else begin
            w_wcnt_nxt = r_wcnt + WCNT_W'(1);
          end
        end else begin
          w_run_eval = 1'b1;
          w_wcnt_nxt = '0;
        end
      end

      default: w_state_nxt = RUN;
    endcase

    // Shared RUN evaluation, also used on the cycle a memory stall releases.
    if (w_run_eval) begin
      if (bus.mem_busy) begin
        w_ctrl.if_stall = 1'b1;
        w_ctrl.id_stall = 1'b1;
        w_ctrl.ex_stall = 1'b1;
        w_state_nxt     = MEM_WAIT;
        w_wcnt_nxt      = WCNT_W'(1);
      end else if (bus.ex_branch_taken) begin
        w_redirect      = 1'b1;
        w_misalign      = |bus.ex_branch_target[1:0];
        w_ctrl.id_flush = 1'b1;
        w_ctrl.ex_flush = 1'b1;
        w_fcnt_nxt      = FCNT_W'(FLUSH_DEPTH - 1);
        w_state_nxt     = (FLUSH_DEPTH > 1) ? FLUSH : RUN;
      end else if (w_load_use) begin
        w_ctrl.if_stall = 1'b1;
        w_ctrl.id_stall = 1'b1;
        w_ctrl.ex_flush = 1'b1;
        w_state_nxt     = LOAD_STALL;
      end else begin
        w_state_nxt = RUN;
      end
    end

    if (reset) begin
      w_ctrl     = '0;
      w_redirect = 1'b0;
      w_misalign = 1'b0;
    end
  end

  assign bus.if_stall       = w_ctrl.if_stall;
  assign bus.id_stall       = w_ctrl.id_stall;
  assign bus.ex_stall       = w_ctrl.ex_stall;
  assign bus.id_flush       = w_ctrl.id_flush;
  assign bus.ex_flush       = w_ctrl.ex_flush;
  assign bus.redirect_valid = w_redirect;
  assign bus.redirect_pc    = w_redirect ? {bus.ex_branch_target[XLEN-1:2], 2'b00} : '0;
  assign bus.misalign_err   = w_misalign;
  assign bus.mem_timeout    = r_mem_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_lu;
  logic        w_lu_evt;

  // if_stall together with ex_flush only arises from a load-use bubble.
  assign w_lu_evt = w_ctrl.if_stall & w_ctrl.ex_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_lu    <= '0;
    end else begin
      if (w_ctrl.if_stall) r_perf_stall <= sat_inc32(r_perf_stall);
      if (w_redirect)      r_perf_flush <= sat_inc32(r_perf_flush);
      if (w_lu_evt)        r_perf_lu    <= sat_inc32(r_perf_lu);
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flushes      = r_perf_flush;
  assign perf_loaduse      = r_perf_lu;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven scoreboard bench for pipeline_hazard_ctrl (default parameters).
module tb_pipeline_hazard_ctrl;

  typedef struct {
    string       name;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        mr;
    logic        bt;
    logic [31:0] tgt;
    logic        busy;
    logic        rst;
    logic [7:0]  exp;  // {if,id,ex stall, id,ex flush, redirect, misalign, timeout}
    logic [31:0] pc;
  } vec_t;

  localparam logic [7:0] E_NONE = 8'h00;
  localparam logic [7:0] E_LU   = 8'hC8;
  localparam logic [7:0] E_BR   = 8'h1C;
  localparam logic [7:0] E_BRM  = 8'h1E;
  localparam logic [7:0] E_FL   = 8'h10;
  localparam logic [7:0] E_MEM  = 8'hE0;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t tbl[$];
  vec_t sb_q[$];

  pipeline_hazard_ctrl_if #(.XLEN(32)) bus ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_loaduse;
  pipeline_hazard_ctrl dut (
    .clk (clk), .reset (reset), .bus (bus),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_loaduse      (perf_loaduse)
  );
`else
  pipeline_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic mr, input logic bt, input logic [31:0] tgt,
                              input logic busy, input logic rst, input logic [7:0] exp,
                              input logic [31:0] pc);
    vec_t v;
    v.name = n; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
    v.mr = mr; v.bt = bt; v.tgt = tgt; v.busy = busy; v.rst = rst;
    v.exp = exp; v.pc = pc;
    return v;
  endfunction

  function automatic vec_t idle(input string n, input logic [7:0] exp);
    return mk(n, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, exp, 32'h0);
  endfunction

  function automatic vec_t br(input string n, input logic [31:0] tgt, input logic [7:0] exp,
                              input logic [31:0] pc);
    return mk(n, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, tgt, 1'b0, 1'b0, exp, pc);
  endfunction

  function automatic vec_t lu(input string n, input logic [7:0] exp);
    return mk(n, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, exp, 32'h0);
  endfunction

  function automatic vec_t busy_v(input string n, input logic bt, input logic [31:0] tgt,
                                  input logic [7:0] exp);
    return mk(n, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, bt, tgt, 1'b1, 1'b0, exp, 32'h0);
  endfunction

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    reset                = v.rst;
    bus.id_rs1           = v.rs1;
    bus.id_use_rs1       = v.u1;
    bus.id_rs2           = v.rs2;
    bus.id_use_rs2       = v.u2;
    bus.ex_rd            = v.rd;
    bus.ex_mem_read      = v.mr;
    bus.ex_branch_taken  = v.bt;
    bus.ex_branch_target = v.tgt;
    bus.mem_busy         = v.busy;
    sb_q.push_back(v);
  endtask

  // Outputs are Mealy; compare mid-cycle after inputs have settled.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      vec_t e;
      logic [7:0] got;
      e   = sb_q.pop_front();
      got = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.id_flush, bus.ex_flush,
             bus.redirect_valid, bus.misalign_err, bus.mem_timeout};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s flags: got %b want %b", e.name, got, e.exp);
      end
      checks++;
      if (bus.redirect_pc !== e.pc) begin
        errors++;
        $display("FAIL %s redirect_pc: got %h want %h", e.name, bus.redirect_pc, e.pc);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_rd = '0; bus.ex_mem_read = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.ex_branch_target = '0; bus.mem_busy = 1'b0;

    tbl.push_back(mk("reset_gate", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 32'h104,
                     1'b1, 1'b1, E_NONE, 32'h0));
    tbl.push_back(idle("idle", E_NONE));
    tbl.push_back(lu("loaduse_rs1", E_LU));
    tbl.push_back(lu("load_stall", E_NONE));
    tbl.push_back(idle("after_ls", E_NONE));
    tbl.push_back(mk("rd_zero", 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, E_NONE, 32'h0));
    tbl.push_back(mk("loaduse_rs2", 5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, E_LU, 32'h0));
    tbl.push_back(idle("load_stall2", E_NONE));
    tbl.push_back(mk("rs2_unused", 5'd3, 1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 32'h0,
                     1'b0, 1'b0, E_NONE, 32'h0));
    tbl.push_back(mk("not_load", 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b0, E_NONE, 32'h0));
    tbl.push_back(br("branch", 32'h100, E_BR, 32'h100));
    tbl.push_back(idle("flush_2nd", E_FL));
    tbl.push_back(idle("flush_done", E_NONE));
    tbl.push_back(br("branch_mis", 32'h102, E_BRM, 32'h100));
    tbl.push_back(idle("flush_mis", E_FL));
    tbl.push_back(mk("br_over_lu", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 32'h200,
                     1'b0, 1'b0, E_BR, 32'h200));
    tbl.push_back(lu("lu_in_flush", E_FL));
    tbl.push_back(busy_v("mem_br_1", 1'b1, 32'h300, E_MEM));
    tbl.push_back(busy_v("mem_br_2", 1'b1, 32'h300, E_MEM));
    tbl.push_back(busy_v("mem_br_3", 1'b1, 32'h300, E_MEM));
    tbl.push_back(br("mem_release", 32'h300, E_BR, 32'h300));
    tbl.push_back(busy_v("flush_to_mem", 1'b0, 32'h0, E_MEM));
    tbl.push_back(idle("mem_rel_idle", E_NONE));
    tbl.push_back(idle("no_stale_flush", E_NONE));
    tbl.push_back(br("br_restart_a", 32'h400, E_BR, 32'h400));
    tbl.push_back(br("br_restart_b", 32'h501, E_BRM, 32'h500));
    tbl.push_back(idle("restart_flush", E_FL));
    tbl.push_back(idle("restart_done", E_NONE));
    tbl.push_back(lu("ls_then_mem", E_LU));
    tbl.push_back(busy_v("ls_mem", 1'b0, 32'h0, E_MEM));
    tbl.push_back(idle("ls_mem_rel", E_NONE));

    // Timeout: counter hits MEM_TIMEOUT in busy cycle 15, flag visible from cycle 16.
    for (int k = 0; k < 20; k++)
      tbl.push_back(busy_v("timeout", 1'b0, 32'h0, E_MEM | ((k >= 16) ? 8'h01 : 8'h00)));
    tbl.push_back(idle("timeout_sticky", 8'h01));
    tbl.push_back(idle("timeout_sticky2", 8'h01));
    tbl.push_back(mk("timeout_clr", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0,
                     1'b0, 1'b1, E_NONE, 32'h0));
    tbl.push_back(idle("after_clr", E_NONE));

    // Reset mid-FLUSH aborts with no further id_flush or redirect replay.
    tbl.push_back(br("br_then_rst", 32'h600, E_BR, 32'h600));
    tbl.push_back(mk("rst_in_flush", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h700,
                     1'b0, 1'b1, E_NONE, 32'h0));
    tbl.push_back(idle("post_rst_1", E_NONE));
    tbl.push_back(idle("post_rst_2", E_NONE));

    foreach (tbl[i]) drive(tbl[i]);

    begin : drain
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d entries left, want 0", sb_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
